// File: rtl/conv_row_feeder.sv
// Frame buffer and row sequencer for the 3x3 convolution stage: stores a
// D-channel frame of unpadded rows, then presents zero-padded row triplets per (row, depth).
module conv_row_feeder #(
   parameter int unsigned D          = 4,
   parameter int unsigned H          = 6,
   parameter int unsigned W          = 6,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rstn_i,
   input  logic [DATA_WIDTH*W-1:0]        pix_row_i,
   input  logic                           pix_valid_i,
   output logic                           pix_ready_o,
   output logic [DATA_WIDTH*(W+2)-1:0]    image0_o,
   output logic [DATA_WIDTH*(W+2)-1:0]    image1_o,
   output logic [DATA_WIDTH*(W+2)-1:0]    image2_o,
   output logic                           image_start_o,
   input  logic                           conv_done_i,
   output logic                           busy_o,
   output logic                           frame_done_o
);

   localparam int unsigned ROW_W = DATA_WIDTH * W;
   localparam int unsigned PAD_W = DATA_WIDTH * (W + 2);
   localparam int unsigned N     = D * H;
   localparam int unsigned AW    = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned DW    = (D > 1) ? $clog2(D) : 1;
   localparam int unsigned HW    = (H > 1) ? $clog2(H) : 1;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [AW-1:0]       wr_cnt_q, wr_cnt_d;
   logic [DW-1:0]       d_q, d_d;
   logic [HW-1:0]       r_q, r_d;
   logic [PAD_W-1:0]    img0_q, img0_d;
   logic [PAD_W-1:0]    img1_q, img1_d;
   logic [PAD_W-1:0]    img2_q, img2_d;
   logic                start_q, start_d;
   logic                fdone_q, fdone_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                wr_en_c;
   logic [AW-1:0]       idx_mid_c, idx_up_c, idx_dn_c;
   logic                row_first_c, row_last_c, depth_last_c, wr_last_c;

   logic [ROW_W-1:0]    mem_q [N];

   // Zero pixel on each side of the stored row.
   function automatic logic [PAD_W-1:0] pad_row(input logic [ROW_W-1:0] row);
      return {{DATA_WIDTH{1'b0}}, row, {DATA_WIDTH{1'b0}}};
   endfunction

   always_comb begin
      idx_mid_c    = AW'(32'(d_q) * H + 32'(r_q));
      idx_up_c     = idx_mid_c - AW'(1);
      idx_dn_c     = idx_mid_c + AW'(1);
      row_first_c  = (r_q == '0);
      row_last_c   = (r_q == HW'(H - 1));
      depth_last_c = (d_q == DW'(D - 1));
      wr_last_c    = (wr_cnt_q == AW'(N - 1));
   end

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      d_d      = d_q;
      r_d      = r_q;
      img0_d   = img0_q;
      img1_d   = img1_q;
      img2_d   = img2_q;
      start_d  = 1'b0;
      fdone_d  = 1'b0;
      wr_en_c  = 1'b0;

      unique case (state_q)
         ST_LOAD: begin
            if (pix_valid_i) begin
               wr_en_c = 1'b1;
               if (wr_last_c) begin
                  wr_cnt_d = '0;
                  d_d      = '0;
                  r_d      = '0;
                  state_d  = ST_ISSUE;
               end else begin
                  wr_cnt_d = wr_cnt_q + AW'(1);
               end
            end
         end
         ST_ISSUE: begin
            img0_d  = row_first_c ? '0 : pad_row(mem_q[idx_up_c]);
            img1_d  = pad_row(mem_q[idx_mid_c]);
            img2_d  = row_last_c ? '0 : pad_row(mem_q[idx_dn_c]);
            start_d = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A done coincident with the start pulse belongs to the previous job.
            if (conv_done_i && !start_q) begin
               if (!depth_last_c) begin
                  d_d     = d_q + DW'(1);
                  state_d = ST_ISSUE;
               end else if (!row_last_c) begin
                  d_d     = '0;
                  r_d     = r_q + HW'(1);
                  state_d = ST_ISSUE;
               end else begin
                  d_d      = '0;
                  r_d      = '0;
                  wr_cnt_d = '0;
                  fdone_d  = 1'b1;
                  state_d  = ST_LOAD;
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase

      ready_d = (state_d == ST_LOAD);
      busy_d  = (state_d != ST_LOAD);
   end

   always_ff @(posedge clk) begin
      if (rstn_i) begin
         state_q  <= ST_LOAD;
         wr_cnt_q <= '0;
         d_q      <= '0;
         r_q      <= '0;
         img0_q   <= '0;
         img1_q   <= '0;
         img2_q   <= '0;
         start_q  <= 1'b0;
         fdone_q  <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         d_q      <= d_d;
         r_q      <= r_d;
         img0_q   <= img0_d;
         img1_q   <= img1_d;
         img2_q   <= img2_d;
         start_q  <= start_d;
         fdone_q  <= fdone_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   // Frame storage survives reset.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem_q[wr_cnt_q] <= pix_row_i;
      end
   end

   assign pix_ready_o   = ready_q;
   assign image0_o      = img0_q;
   assign image1_o      = img1_q;
   assign image2_o      = img2_q;
   assign image_start_o = start_q;
   assign busy_o        = busy_q;
   assign frame_done_o  = fdone_q;

endmodule

// File: tb/tb_conv_row_feeder.sv
// Scoreboard bench for conv_row_feeder: random frames, random backpressure and stray
// done pulses, checked against a pixel-array reference model.
module tb_conv_row_feeder;

   localparam int unsigned D    = 4;
   localparam int unsigned H    = 6;
   localparam int unsigned W    = 6;
   localparam int unsigned DWID = 8;
   localparam int unsigned RW   = DWID * W;
   localparam int unsigned PW   = DWID * (W + 2);

   typedef struct {
      logic [PW-1:0] i0;
      logic [PW-1:0] i1;
      logic [PW-1:0] i2;
      int            r;
      int            d;
   } exp_t;

   logic          clk;
   logic          rstn_i;
   logic [RW-1:0] pix_row_i;
   logic          pix_valid_i;
   logic          pix_ready_o;
   logic [PW-1:0] image0_o, image1_o, image2_o;
   logic          image_start_o;
   logic          conv_done_i;
   logic          busy_o;
   logic          frame_done_o;

   int checks   = 0;
   int failures = 0;
   int n_starts = 0;
   int n_fdone  = 0;

   exp_t          sb[$];
   logic [DWID-1:0] ref_pix [D][H][W];

   conv_row_feeder #(.D(D), .H(H), .W(W), .DATA_WIDTH(DWID)) dut (
      .clk           (clk),
      .rstn_i        (rstn_i),
      .pix_row_i     (pix_row_i),
      .pix_valid_i   (pix_valid_i),
      .pix_ready_o   (pix_ready_o),
      .image0_o      (image0_o),
      .image1_o      (image1_o),
      .image2_o      (image2_o),
      .image_start_o (image_start_o),
      .conv_done_i   (conv_done_i),
      .busy_o        (busy_o),
      .frame_done_o  (frame_done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PW-1:0] pad_ref(input int d, input int r);
      logic [PW-1:0] v;
      v = '0;
      for (int j = 1; j <= int'(W); j++) v[DWID*j +: DWID] = ref_pix[d][r][j-1];
      return v;
   endfunction

   function automatic logic [RW-1:0] junk_row();
      logic [RW-1:0] v;
      for (int i = 0; i < int'(W); i++) v[DWID*i +: DWID] = DWID'($urandom);
      return v;
   endfunction

   // Monitor: scoreboard compare on every start, hold check during the job.
   logic [PW-1:0] last0, last1, last2;
   bit hold_ok = 1'b0;
   always @(negedge clk) begin
      if (frame_done_o === 1'b1) n_fdone++;
      if (rstn_i) begin
         hold_ok = 1'b0;
      end else if (image_start_o === 1'b1) begin
         n_starts++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_start actual=start required=none");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("image0 r%0d d%0d", e.r, e.d), image0_o, e.i0);
            chk($sformatf("image1 r%0d d%0d", e.r, e.d), image1_o, e.i1);
            chk($sformatf("image2 r%0d d%0d", e.r, e.d), image2_o, e.i2);
         end
         last0 = image0_o; last1 = image1_o; last2 = image2_o;
         hold_ok = 1'b1;
      end else if (hold_ok && busy_o === 1'b1) begin
         chk("hold image0", image0_o, last0);
         chk("hold image1", image1_o, last1);
         chk("hold image2", image2_o, last2);
      end
   end

   task automatic load_frame(input bit pattern, input bit rnd);
      int idx = 0;
      int guard = 0;
      int d, r;
      bit v, acc;
      logic [DWID-1:0] px [W];
      logic [RW-1:0] row;
      while (idx < int'(D * H) && guard < 4000) begin
         d = idx / int'(H);
         r = idx % int'(H);
         for (int i = 0; i < int'(W); i++)
            px[i] = pattern ? DWID'({2'(d), 3'(r), 3'(i)}) : DWID'($urandom);
         v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         row = junk_row();
         if (v) for (int i = 0; i < int'(W); i++) row[DWID*i +: DWID] = px[i];
         pix_valid_i = v;
         pix_row_i   = row;
         acc = v && pix_ready_o;
         tick();
         if (acc) begin
            for (int i = 0; i < int'(W); i++) ref_pix[d][r][i] = px[i];
            idx++;
         end
         guard++;
      end
      pix_valid_i = 1'b0;
      if (idx != int'(D * H)) begin
         checks++;
         failures++;
         $display("FAIL load_timeout accepted=%0d required=%0d", idx, D * H);
      end
      for (int r2 = 0; r2 < int'(H); r2++)
         for (int d2 = 0; d2 < int'(D); d2++) begin
            exp_t e;
            e.r  = r2;
            e.d  = d2;
            e.i0 = (r2 == 0) ? '0 : pad_ref(d2, r2 - 1);
            e.i1 = pad_ref(d2, r2);
            e.i2 = (r2 == int'(H) - 1) ? '0 : pad_ref(d2, r2 + 1);
            sb.push_back(e);
         end
   endtask

   // Called right after the final accepting edge.
   task automatic first_issue_timing();
      chk("ready_drop", pix_ready_o, 0);
      chk("busy_rise", busy_o, 1);
      chk("no_early_start", image_start_o, 0);
      tick();
      chk("first_start_latency", image_start_o, 1);
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (image_start_o) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL start_timeout actual=no_start required=start");
      end
   endtask

   task automatic run_seq(input int stop_at, input bit hold);
      bit ok;
      int n = int'(D * H);
      for (int k = 0; k < n; k++) begin
         wait_start(ok);
         if (!ok) return;
         if (hold) begin
            pix_valid_i = 1'b1;
            pix_row_i   = junk_row();
         end
         if (k == 0 || $urandom_range(0, 1) == 1) conv_done_i = 1'b1;
         tick();
         conv_done_i = 1'b0;
         if (k == stop_at) begin
            pix_valid_i = 1'b0;
            tick();
            rstn_i = 1'b1;
            tick();
            rstn_i = 1'b0;
            return;
         end
         repeat (3) tick();
         if (k == n - 1) pix_valid_i = 1'b0;
         conv_done_i = 1'b1;
         tick();
         conv_done_i = 1'b0;
         if (k == n - 1) begin
            chk("frame_done_pulse", frame_done_o, 1);
            chk("ready_after_frame", pix_ready_o, 1);
            chk("busy_after_frame", busy_o, 0);
         end else begin
            chk("no_frame_done_mid", frame_done_o, 0);
         end
      end
   endtask

   task automatic reset_state_checks(input string tag);
      chk({tag, " ready"}, pix_ready_o, 1);
      chk({tag, " busy"}, busy_o, 0);
      chk({tag, " start"}, image_start_o, 0);
      chk({tag, " frame_done"}, frame_done_o, 0);
      chk({tag, " image0"}, image0_o, '0);
      chk({tag, " image1"}, image1_o, '0);
      chk({tag, " image2"}, image2_o, '0);
   endtask

   initial begin
      int fd_before;
      rstn_i      = 1'b1;
      pix_valid_i = 1'b0;
      pix_row_i   = '0;
      conv_done_i = 1'b0;
      tick();
      tick();
      rstn_i = 1'b0;
      reset_state_checks("reset");

      // Frame 1: patterned pixels, stray done held high through load and first start.
      conv_done_i = 1'b1;
      load_frame(1'b1, 1'b0);
      first_issue_timing();
      run_seq(-1, 1'b1);

      // Frame 2: back-to-back random frame with random backpressure.
      load_frame(1'b0, 1'b1);
      first_issue_timing();
      run_seq(-1, 1'b1);

      // Frame 3: reset during the WAIT of (r2,d1).
      load_frame(1'b0, 1'b1);
      first_issue_timing();
      fd_before = n_fdone;
      run_seq(int'(2 * D + 1), 1'b1);
      reset_state_checks("midreset");
      chk("midreset no_frame_done", 32'(n_fdone), 32'(fd_before));
      sb.delete();

      // Frame 4: fresh load after reset.
      load_frame(1'b0, 1'b1);
      first_issue_timing();
      run_seq(-1, 1'b0);

      tick();
      chk("total_starts", 32'(n_starts), 32'(3 * D * H + 2 * D + 2));
      chk("total_frame_done", 32'(n_fdone), 32'd3);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
